// File: rtl/fdc_meas_sequencer.sv
// fdc_meas_sequencer: drives the FDC core through reset / gate / settle / sample
// cycles, sums 2^AVG_LOG2 samples per enabled channel and hands each sum out on
// a valid/ready port. Every output is a register loaded from next-state values.
module fdc_meas_sequencer #(
  parameter int DW         = 5,
  parameter int AVG_LOG2   = 2,
  parameter int RST_CYC    = 4,
  parameter int GATE_CYC   = 64,
  parameter int SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             chan_mask,
  input  logic                   continuous,
  input  logic [DW-1:0]          fdc_out,
  output logic                   fdc_reset,
  output logic                   fdc_selec,
  output logic [DW+AVG_LOG2-1:0] res_data,
  output logic                   res_chan,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   busy
);

  localparam int RW = DW + AVG_LOG2;   // accumulator wide enough to never overflow
  localparam int CW = AVG_LOG2 + 1;    // sample counter must reach 2^AVG_LOG2
  localparam int TW = 16;              // phase timer width

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_GATE, S_SETTLE, S_SAMPLE, S_OUT
  } state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [RW-1:0]   acc_reg, acc_next;
  logic [1:0]      mask_reg, mask_next;
  logic [1:0]      done_reg, done_next;   // channels already reported this sweep
  logic            chan_reg, chan_next;
  logic            fdc_reset_reg, fdc_reset_next;
  logic            fdc_selec_reg, fdc_selec_next;
  logic [RW-1:0]   res_data_reg, res_data_next;
  logic            res_chan_reg, res_chan_next;
  logic            res_valid_reg, res_valid_next;
  logic            busy_reg, busy_next;
  logic [1:0]      remaining;

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      timer_reg     <= '0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      mask_reg      <= '0;
      done_reg      <= '0;
      chan_reg      <= 1'b0;
      fdc_reset_reg <= 1'b1;
      fdc_selec_reg <= 1'b0;
      res_data_reg  <= '0;
      res_chan_reg  <= 1'b0;
      res_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      cnt_reg       <= cnt_next;
      acc_reg       <= acc_next;
      mask_reg      <= mask_next;
      done_reg      <= done_next;
      chan_reg      <= chan_next;
      fdc_reset_reg <= fdc_reset_next;
      fdc_selec_reg <= fdc_selec_next;
      res_data_reg  <= res_data_next;
      res_chan_reg  <= res_chan_next;
      res_valid_reg <= res_valid_next;
      busy_reg      <= busy_next;
    end
  end

  // Next-state sequencing; outputs are derived from the state being entered.
  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    cnt_next      = cnt_reg;
    acc_next      = acc_reg;
    mask_next     = mask_reg;
    done_next     = done_reg;
    chan_next     = chan_reg;
    res_data_next = res_data_reg;
    res_chan_next = res_chan_reg;
    remaining     = 2'b00;

    case (state_reg)
      S_IDLE: begin
        if (start && (chan_mask != 2'b00)) begin
          state_next = S_RST;
          timer_next = TW'(RST_CYC - 1);
          mask_next  = chan_mask;
          chan_next  = ~chan_mask[0];     // lowest set bit
          done_next  = 2'b00;
          acc_next   = '0;
          cnt_next   = '0;
        end
      end
      S_RST: begin
        if (timer_reg == '0) begin
          state_next = S_GATE;
          timer_next = TW'(GATE_CYC - 1);
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      S_GATE: begin
        if (timer_reg == '0) begin
          state_next = S_SETTLE;
          timer_next = TW'(SETTLE_CYC - 1);
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      S_SETTLE: begin
        if (timer_reg == '0) begin
          state_next = S_SAMPLE;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      S_SAMPLE: begin
        acc_next = acc_reg + RW'(fdc_out);
        cnt_next = cnt_reg + 1'b1;
        if (cnt_next == CW'(2 ** AVG_LOG2)) begin
          state_next    = S_OUT;
          res_data_next = acc_next;
          res_chan_next = chan_reg;
        end else begin
          state_next = S_RST;
          timer_next = TW'(RST_CYC - 1);
        end
      end
      S_OUT: begin
        // res_valid is always high while in OUT, so ready alone completes the transfer
        if (res_ready) begin
          done_next = done_reg | (chan_reg ? 2'b10 : 2'b01);
          remaining = mask_reg & ~done_next;
          acc_next  = '0;
          cnt_next  = '0;
          if (remaining != 2'b00) begin
            state_next = S_RST;
            timer_next = TW'(RST_CYC - 1);
            chan_next  = ~remaining[0];
          end else if (continuous) begin
            state_next = S_RST;
            timer_next = TW'(RST_CYC - 1);
            chan_next  = ~mask_reg[0];
            done_next  = 2'b00;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    // abort discards any pending result but keeps the last result registers
    if (abort) begin
      state_next = S_IDLE;
    end

    // the core free-runs through gate and settle and is held in reset otherwise
    fdc_reset_next = !((state_next == S_GATE) || (state_next == S_SETTLE));
    // channel select only moves on entry to RST, while the core is in reset
    fdc_selec_next = (state_next == S_RST) ? chan_next : fdc_selec_reg;
    res_valid_next = (state_next == S_OUT);
    busy_next      = (state_next != S_IDLE);
  end

  assign fdc_reset = fdc_reset_reg;
  assign fdc_selec = fdc_selec_reg;
  assign res_data  = res_data_reg;
  assign res_chan  = res_chan_reg;
  assign res_valid = res_valid_reg;
  assign busy      = busy_reg;

endmodule
